// File: rtl/knapsack_pkg.sv
// Shared types and helpers for the sequential knapsack evaluator.
// The coefficient struct width is fixed by COEF_WIDTH; the top-level
// COEF_W parameter defaults to it and must track it.
package knapsack_pkg;

  localparam int COEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [COEF_WIDTH-1:0] value;
    logic [COEF_WIDTH-1:0] weight;
    logic [COEF_WIDTH-1:0] volume;
  } coef_t;

  // Wide enough to sum every item at full scale without wrapping.
  function automatic int acc_width(input int coef_w, input int n_items);
    return coef_w + $clog2(n_items + 1);
  endfunction

endpackage

// File: rtl/knapsack_seq_eval_if.sv
// Candidate-in / result-out handshake bundle for knapsack_seq_eval.
// master = candidate generator + result collector, slave = evaluator.
interface knapsack_seq_eval_if #(
  parameter int N_ITEMS = 5,
  parameter int ACC_W   = 11
);
  logic               cand_valid;
  logic               cand_ready;
  logic [N_ITEMS-1:0] cand_sel;
  logic               res_valid;
  logic               res_ready;
  logic               res_feasible;
  logic [ACC_W-1:0]   res_value;
  logic [ACC_W-1:0]   res_weight;
  logic [ACC_W-1:0]   res_volume;

  modport master (
    output cand_valid, cand_sel, res_ready,
    input  cand_ready, res_valid, res_feasible, res_value, res_weight, res_volume
  );

  modport slave (
    input  cand_valid, cand_sel, res_ready,
    output cand_ready, res_valid, res_feasible, res_value, res_weight, res_volume
  );
endinterface

// File: rtl/knapsack_coef_table.sv
// Per-item coefficient register file: one write port, one combinational
// read port. Out-of-range write indices are ignored.
module knapsack_coef_table
  import knapsack_pkg::*;
#(
  parameter int N_ITEMS = 5,
  parameter int IDX_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  coef_t            wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output coef_t            rd_data
);

  coef_t mem [N_ITEMS];

  // Table storage; cleared by reset, written only for valid indices.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ITEMS; i++) mem[i] <= '0;
    end else if (we && (32'(wr_idx) < N_ITEMS)) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/knapsack_seq_eval.sv
// Sequential knapsack candidate evaluator: accepts a selection vector,
// sums value/weight/volume one item per cycle from a loadable table and
// reports feasibility against thresholds latched at acceptance.
// Optional best-feasible tracking is enabled by defining BEST_TRACK_EN.
module knapsack_seq_eval
  import knapsack_pkg::*;
#(
  parameter int  N_ITEMS = 5,
  parameter int  COEF_W  = COEF_WIDTH,
  localparam int ACC_W   = acc_width(COEF_W, N_ITEMS),
  localparam int IDX_W   = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [COEF_W-1:0]   cfg_value,
  input  logic [COEF_W-1:0]   cfg_weight,
  input  logic [COEF_W-1:0]   cfg_volume,
  input  logic [ACC_W-1:0]    min_value,
  input  logic [ACC_W-1:0]    max_weight,
  input  logic [ACC_W-1:0]    max_volume,
  knapsack_seq_eval_if.slave  bus,
  output logic                best_valid,
  output logic [ACC_W-1:0]    best_value,
  output logic [N_ITEMS-1:0]  best_sel
);

  state_t             state, state_nxt;
  logic [N_ITEMS-1:0] sel_q;
  logic [ACC_W-1:0]   min_q, maxw_q, maxv_q;
  logic [ACC_W-1:0]   acc_val, acc_wt, acc_vol;
  logic [IDX_W-1:0]   idx;
  logic               last_item;
  logic               feasible;
  logic               done_fresh;
  coef_t              rd_coef;
  coef_t              wr_coef;

  assign last_item = (idx == IDX_W'(N_ITEMS - 1));
  assign wr_coef   = '{value: cfg_value, weight: cfg_weight, volume: cfg_volume};

  // Writes land only while idle, so an in-flight sum never sees a torn table.
  knapsack_coef_table #(.N_ITEMS(N_ITEMS), .IDX_W(IDX_W)) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we && (state == IDLE)),
    .wr_idx  (cfg_idx),
    .wr_data (wr_coef),
    .rd_idx  (idx),
    .rd_data (rd_coef)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cand_valid) state_nxt = ACCUM;
      ACCUM:   if (last_item)      state_nxt = DONE;
      DONE:    if (bus.res_ready)  state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Candidate capture and per-item accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q      <= '0;
      min_q      <= '0;
      maxw_q     <= '0;
      maxv_q     <= '0;
      acc_val    <= '0;
      acc_wt     <= '0;
      acc_vol    <= '0;
      idx        <= '0;
      done_fresh <= 1'b0;
    end else begin
      done_fresh <= (state == ACCUM) && last_item;
      case (state)
        IDLE: begin
          if (bus.cand_valid) begin
            sel_q   <= bus.cand_sel;
            min_q   <= min_value;
            maxw_q  <= max_weight;
            maxv_q  <= max_volume;
            acc_val <= '0;
            acc_wt  <= '0;
            acc_vol <= '0;
            idx     <= '0;
          end
        end
        ACCUM: begin
          if (sel_q[idx]) begin
            acc_val <= acc_val + ACC_W'(rd_coef.value);
            acc_wt  <= acc_wt  + ACC_W'(rd_coef.weight);
            acc_vol <= acc_vol + ACC_W'(rd_coef.volume);
          end
          if (!last_item) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign feasible         = (acc_val >= min_q) && (acc_wt <= maxw_q) && (acc_vol <= maxv_q);
  assign bus.cand_ready   = (state == IDLE);
  assign bus.res_valid    = (state == DONE);
  assign bus.res_feasible = (state == DONE) && feasible;
  assign bus.res_value    = acc_val;
  assign bus.res_weight   = acc_wt;
  assign bus.res_volume   = acc_vol;

`ifdef BEST_TRACK_EN
  logic               best_valid_q;
  logic [ACC_W-1:0]   best_value_q;
  logic [N_ITEMS-1:0] best_sel_q;

  // Record a strictly better feasible result once, on the first DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_valid_q <= 1'b0;
      best_value_q <= '0;
      best_sel_q   <= '0;
    end else if (done_fresh && feasible && (!best_valid_q || (acc_val > best_value_q))) begin
      best_valid_q <= 1'b1;
      best_value_q <= acc_val;
      best_sel_q   <= sel_q;
    end
  end

  assign best_valid = best_valid_q;
  assign best_value = best_value_q;
  assign best_sel   = best_sel_q;
`else
  logic unused_done_fresh;
  assign unused_done_fresh = done_fresh;
  assign best_valid = 1'b0;
  assign best_value = '0;
  assign best_sel   = '0;
`endif

endmodule

// File: tb/tb_knapsack_seq_eval.sv
// Directed scoreboard bench for knapsack_seq_eval (N_ITEMS=5).
module tb_knapsack_seq_eval;
  import knapsack_pkg::*;

  localparam int N     = 5;
  localparam int ACC_W = acc_width(COEF_WIDTH, N);

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_we;
  logic [2:0] cfg_idx;
  logic [7:0] cfg_value, cfg_weight, cfg_volume;
  logic [ACC_W-1:0] min_value, max_weight, max_volume;
  logic best_valid;
  logic [ACC_W-1:0] best_value;
  logic [N-1:0] best_sel;

  knapsack_seq_eval_if #(.N_ITEMS(N), .ACC_W(ACC_W)) bus ();

  knapsack_seq_eval #(.N_ITEMS(N), .COEF_W(COEF_WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_value  (cfg_value),
    .cfg_weight (cfg_weight),
    .cfg_volume (cfg_volume),
    .min_value  (min_value),
    .max_weight (max_weight),
    .max_volume (max_volume),
    .bus        (bus.slave),
    .best_valid (best_valid),
    .best_value (best_value),
    .best_sel   (best_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] sel;
    int v, w, o;
    bit feas;
  } exp_t;

  exp_t q[$];
  int   mv[N], mw[N], mo[N];
  bit   m_best_ok;
  int   m_best_v;
  int   m_best_s;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] sel, input int mn, input int mxw, input int mxo);
    exp_t e;
    e.sel = sel; e.v = 0; e.w = 0; e.o = 0;
    for (int i = 0; i < N; i++)
      if (sel[i]) begin e.v += mv[i]; e.w += mw[i]; e.o += mo[i]; end
    e.feas = (e.v >= mn) && (e.w <= mxw) && (e.o <= mxo);
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin mv[i] = 0; mw[i] = 0; mo[i] = 0; end
    m_best_ok = 0; m_best_v = 0; m_best_s = 0;
  endtask

  task automatic cfg_write(input int idx, input int v, input int w, input int o);
    @(negedge clk);
    cfg_we = 1; cfg_idx = 3'(idx); cfg_value = 8'(v); cfg_weight = 8'(w); cfg_volume = 8'(o);
    @(negedge clk);
    cfg_we = 0;
    if (idx < N) begin mv[idx] = v; mw[idx] = w; mo[idx] = o; end
  endtask

  // Present a candidate; on return we sit at a negedge with res_valid seen (or timed out).
  task automatic submit(input logic [N-1:0] sel, input int mn, input int mxw, input int mxo);
    int lat;
    int wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    while (!bus.cand_ready && wait_cnt < 50) begin @(negedge clk); wait_cnt++; end
    chk("cand_ready_wait", 32'(bus.cand_ready), 1);
    bus.cand_valid = 1; bus.cand_sel = sel;
    min_value = ACC_W'(mn); max_weight = ACC_W'(mxw); max_volume = ACC_W'(mxo);
    q.push_back(model(sel, mn, mxw, mxo));
    @(negedge clk);
    bus.cand_valid = 0;
    // Scramble thresholds: the in-flight candidate must keep its own.
    min_value = '1; max_weight = '0; max_volume = '0;
    lat = 1;
    while (!bus.res_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), 6);
  endtask

  task automatic finish_result(input int stall);
    exp_t e;
    logic [ACC_W-1:0] v0;
    chk("queue_nonempty", 32'(q.size() != 0), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("res_value",    32'(bus.res_value),    32'(e.v));
      chk("res_weight",   32'(bus.res_weight),   32'(e.w));
      chk("res_volume",   32'(bus.res_volume),   32'(e.o));
      chk("res_feasible", 32'(bus.res_feasible), 32'(e.feas));
      v0 = bus.res_value;
      for (int s = 0; s < stall; s++) begin
        bus.cand_valid = 1; bus.cand_sel = '1;
        cfg_we = 1; cfg_idx = 3'd0; cfg_value = 8'd99; cfg_weight = 8'd99; cfg_volume = 8'd99;
        @(negedge clk);
        chk("stall_res_valid",  32'(bus.res_valid),  1);
        chk("stall_cand_ready", 32'(bus.cand_ready), 0);
        chk("stall_value",      32'(bus.res_value),  32'(v0));
      end
      bus.cand_valid = 0; cfg_we = 0;
      bus.res_ready = 1;
      @(negedge clk);
      bus.res_ready = 0;
      chk("done_one_cycle", 32'(bus.res_valid),  0);
      chk("back_idle",      32'(bus.cand_ready), 1);
`ifdef BEST_TRACK_EN
      if (e.feas && (!m_best_ok || e.v > m_best_v)) begin
        m_best_ok = 1; m_best_v = e.v; m_best_s = int'(e.sel);
      end
`endif
      chk("best_valid", 32'(best_valid), 32'(m_best_ok));
      chk("best_value", 32'(best_value), 32'(m_best_v));
      chk("best_sel",   32'(best_sel),   32'(m_best_s));
    end
  endtask

  task automatic run(input logic [N-1:0] sel, input int mn, input int mxw, input int mxo, input int stall);
    submit(sel, mn, mxw, mxo);
    if (bus.res_valid) finish_result(stall);
  endtask

  initial begin
    int hi;
    rst_n = 0; cfg_we = 0; cfg_idx = 0; cfg_value = 0; cfg_weight = 0; cfg_volume = 0;
    min_value = 0; max_weight = 0; max_volume = 0;
    bus.cand_valid = 0; bus.cand_sel = '0; bus.res_ready = 0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_cand_ready",   32'(bus.cand_ready),   1);
    chk("rst_res_valid",    32'(bus.res_valid),    0);
    chk("rst_res_value",    32'(bus.res_value),    0);
    chk("rst_res_feasible", 32'(bus.res_feasible), 0);
    chk("rst_best_valid",   32'(best_valid),       0);
    rst_n = 1;

    cfg_write(0, 4, 12, 1);
    cfg_write(1, 2, 1, 1);
    cfg_write(2, 2, 2, 1);
    cfg_write(3, 1, 1, 1);
    cfg_write(4, 10, 4, 1);

    run(5'b11110, 15, 16, 10, 0);   // 15/8/4 feasible
    run(5'b11001, 15, 16, 10, 0);   // weight 17 over limit
    run(5'b10001, 15, 16, 10, 0);   // value 14 under minimum
    run(5'b11001, 15, 20, 10, 0);   // feasible tie at 15: earlier best kept
    run(5'b10111, 15, 20, 10, 0);   // 18 feasible: new best
    run(5'b11110, 15, 16, 10, 5);   // stalled DONE with stray cand/cfg traffic
    run(5'b00001, 0, 16, 10, 0);    // table[0] must still be 4/12/1
    run(5'b00000, 0, 16, 10, 0);    // empty, min 0 -> feasible
    run(5'b00000, 1, 16, 10, 0);    // empty, min 1 -> infeasible

    // Out-of-range index must be dropped.
    cfg_write(5, 200, 200, 200);
    run(5'b11111, 0, 100, 100, 0);

    // Write and candidate in the same idle cycle: candidate sees new entry.
    @(negedge clk);
    cfg_we = 1; cfg_idx = 3'd3; cfg_value = 8'd7; cfg_weight = 8'd3; cfg_volume = 8'd2;
    mv[3] = 7; mw[3] = 3; mo[3] = 2;
    bus.cand_valid = 1; bus.cand_sel = 5'b01000;
    min_value = ACC_W'(5); max_weight = ACC_W'(16); max_volume = ACC_W'(10);
    q.push_back(model(5'b01000, 5, 16, 10));
    @(negedge clk);
    cfg_we = 0; bus.cand_valid = 0;
    hi = 1;
    while (!bus.res_valid && hi < 20) begin @(negedge clk); hi++; end
    chk("same_cycle_latency", 32'(hi), 6);
    if (bus.res_valid) finish_result(0);

    // Reset during ACCUM: candidate discarded, table and best cleared.
    @(negedge clk);
    bus.cand_valid = 1; bus.cand_sel = 5'b11111;
    @(negedge clk);
    bus.cand_valid = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_clear();
    hi = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.res_valid !== 1'b0) hi++;
      @(negedge clk);
    end
    chk("rst_mid_res_valid",  32'(hi), 0);
    chk("rst_mid_cand_ready", 32'(bus.cand_ready), 1);
    chk("rst_mid_best_valid", 32'(best_valid), 0);
    run(5'b11111, 0, 0, 0, 0);      // cleared table: all zero, feasible

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
